spi_master_burst: RTL and testbench
===================================

Name: spi_master_burst

Overview:
- Parametrised successor to the byte-wide SPI master.
- Shifts WORD_W-bit words MSB-first in any of the four SPI modes, at a programmable i_Clk-to-SCLK ratio.
- Drives its own active-low chip select and holds it low across a multi-word burst; the host marks the final word with i_TX_Last.
- Sits between host/crypto-core logic and the external SPI pins.

Parameters:
- WORD_W, 8: bits per SPI word, must be >= 2.
- SPI_MODE, 0: 0..3. CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].
- CLKS_PER_HALF_BIT, 2: i_Clk cycles per SCLK half-period, must be >= 2.
- CS_INACTIVE_CLKS, 2: minimum i_Clk cycles CS stays high between bursts, must be >= 1.

Ports:
- i_Clk  in  1  system clock; all logic on the rising edge.
- i_Rst  in  1  asynchronous reset, active-high.
- i_TX_Word  in  WORD_W  word to transmit on MOSI.
- i_TX_DV  in  1  data-valid qualifier for i_TX_Word and i_TX_Last.
- i_TX_Last  in  1  accepted word is the final word of the burst.
- o_TX_Ready  out  1  block can accept a word this cycle.
- o_RX_DV  out  1  one-cycle pulse; o_RX_Word is valid.
- o_RX_Word  out  WORD_W  word sampled from MISO.
- o_SPI_Clk  out  1  SCLK.
- i_SPI_MISO  in  1  serial input.
- o_SPI_MOSI  out  1  serial output.
- o_SPI_CS_n  out  1  chip select, active-low.

Behaviour:
- Reset values (async, while i_Rst = 1):
  - o_SPI_CS_n = 1, o_SPI_Clk = CPOL, o_SPI_MOSI = 0.
  - o_TX_Ready = 0, o_RX_DV = 0, o_RX_Word = 0, state = IDLE.
- o_TX_Ready rises on the first i_Clk edge after i_Rst deasserts.
- Handshake:
  - A word is accepted on a cycle where i_TX_DV & o_TX_Ready.
  - o_TX_Ready is registered and is low from the next cycle onward.
  - i_TX_DV while o_TX_Ready = 0 is ignored; no queuing.
- IDLE: CS_n = 1, SCLK = CPOL, Ready = 1. On accept → CS_SETUP.
- CS_SETUP:
  - CS_n = 0 for CLKS_PER_HALF_BIT cycles, then → SHIFT.
  - If CPHA = 0, MOSI = word MSB from the start of CS_SETUP.
- SHIFT: 2*WORD_W SCLK edges, one every CLKS_PER_HALF_BIT cycles; SCLK period is 2*CLKS_PER_HALF_BIT.
  - CPHA = 0: sample MISO on leading edges; drive the next MOSI bit on trailing edges.
  - CPHA = 1: drive MOSI on leading edges; sample MISO on trailing edges.
  - The leading edge leaves CPOL; the trailing edge returns SCLK to CPOL.
  - Bit counter 0..WORD_W-1 with no wrap inside a word.
  - RX shift register is MSB-first. Exactly WORD_W samples per word.
- Word completion, on the cycle after the final SCLK edge:
  - o_RX_DV = 1 for exactly one cycle; o_RX_Word updates and then holds until the next pulse.
  - If the word was not last → HOLD, with Ready = 1 in the same cycle as o_RX_DV.
  - If it was last → CS_IDLE.
- HOLD:
  - CS_n stays 0, SCLK = CPOL, Ready = 1; the block may wait indefinitely.
  - On accept → SHIFT directly, with no CS_SETUP.
  - If CPHA = 0, MOSI = new MSB on the cycle after accept.
- CS_IDLE: CS_n = 1, Ready = 0 for CS_INACTIVE_CLKS cycles, then → IDLE.
- SCLK edge invariants:
  - No SCLK edge occurs while CS_n = 1.
  - SCLK is at CPOL whenever CS_n changes.
- i_TX_Last is sampled only at accept. A burst of one word means i_TX_Last = 1 on the first word.
- Reset mid-transfer: abort immediately.
  - CS_n = 1 and SCLK = CPOL asynchronously.
  - No o_RX_DV for the partial word.
- MOSI holds its last value between words; its value while CS_n = 1 is don't-care but must be defined (0 after reset).

Test Plan:
1. WORD_W = 8, mode 0, MISO tied to MOSI; send 0xC1 with Last = 1.
   - Required: 16 SCLK edges, each 2 i_Clk apart.
   - Required: one o_RX_DV with o_RX_Word = 0xC1.
   - Required: CS_n low only around the word, then high ≥ 2 cycles with Ready = 0.
2. Loopback burst 0xC1, 0xA2, 0xB3 (Last on 0xB3), each presented the cycle Ready rises.
   - Required: CS_n stays low continuously across all three words.
   - Required: three o_RX_DV pulses carrying 0xC1, 0xA2, 0xB3 in order.
   - Required: CS_n rises after the third pulse.
3. WORD_W = 16, mode 3, CLKS_PER_HALF_BIT = 4, loopback 0xBEEF.
   - Required: SCLK idles high; period is 8 i_Clk.
   - Required: o_RX_Word = 0xBEEF.
4. Mode 1, slave model returns 0x5A on MISO while master sends 0x3C.
   - Required: slave captures 0x3C; master o_RX_Word = 0x5A.
   - Required: sampling occurs on trailing edges only.
5. i_TX_DV held high with 0xFF during a busy 0x12 word.
   - Required: 0xFF is not accepted until Ready returns; no extra RX_DV.
   - Required: words received are 0x12 then 0xFF.
6. Assert i_Rst after the 3rd SCLK edge of 0x77.
   - Required: CS_n = 1 and SCLK = CPOL within the same timestep; no o_RX_DV.
   - Required: Ready = 1 one cycle after release; a fresh 0x77 transfer then completes correctly.

Source files
------------

// File: rtl/spi_master_burst.sv
// -----------------------------------------------------------------------------
// spi_master_burst
//   SPI master shifting WORD_W-bit words MSB-first in any of the four SPI
//   modes. It drives its own active-low chip select and keeps it asserted
//   across a multi-word burst; the host flags the final word with i_TX_Last.
//
// Ports
//   i_Clk, i_Rst        system clock, asynchronous active-high reset
//   i_TX_Word/DV/Last   word to send, its qualifier, end-of-burst marker
//   o_TX_Ready          a word is accepted when i_TX_DV & o_TX_Ready
//   o_RX_DV, o_RX_Word  one-cycle pulse with the word sampled from MISO
//   o_SPI_Clk, o_SPI_MOSI, i_SPI_MISO, o_SPI_CS_n   external SPI pins
// -----------------------------------------------------------------------------
module spi_master_burst #(
    parameter int WORD_W            = 8,
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_INACTIVE_CLKS  = 2
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [WORD_W-1:0] i_TX_Word,
    input  logic              i_TX_DV,
    input  logic              i_TX_Last,
    output logic              o_TX_Ready,
    output logic              o_RX_DV,
    output logic [WORD_W-1:0] o_RX_Word,
    output logic              o_SPI_Clk,
    input  logic              i_SPI_MISO,
    output logic              o_SPI_MOSI,
    output logic              o_SPI_CS_n
);

    localparam logic CPOL = (SPI_MODE & 2) != 0;
    localparam logic CPHA = (SPI_MODE & 1) != 0;

    // One cycle counter serves both the half-bit timer and the CS idle timer.
    localparam int CNT_MAX = (CLKS_PER_HALF_BIT > CS_INACTIVE_CLKS) ?
                             CLKS_PER_HALF_BIT : CS_INACTIVE_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int EDGES   = 2 * WORD_W;
    localparam int EDGE_W  = $clog2(EDGES + 1);

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  CSI_LAST  = CNT_W'(CS_INACTIVE_CLKS - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);
    localparam logic [EDGE_W-1:0] EDGE_DONE = EDGE_W'(EDGES);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        HOLD,
        CS_IDLE
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [EDGE_W-1:0]   edge_q;      // SCLK edges issued in the current word
    logic [WORD_W-1:0]   tx_sh_q;
    logic [WORD_W-1:0]   rx_sh_q;
    logic                last_q;
    logic                sclk_q;
    logic                cs_n_q;
    logic                mosi_q;
    logic                ready_q;
    logic                rx_dv_q;
    logic [WORD_W-1:0]   rx_word_q;

    logic                accept;
    logic                half_tick;
    logic                sample_edge;
    logic [WORD_W-1:0]   tx_sh_d;
    logic [WORD_W-1:0]   rx_sh_d;

    assign accept      = i_TX_DV & ready_q;
    assign half_tick   = (cnt_q == HALF_LAST);
    // Even edge indices are leading edges. CPHA=0 samples on leading edges,
    // CPHA=1 on trailing edges, so the sampling parity equals CPHA.
    assign sample_edge = (edge_q[0] == CPHA);
    assign tx_sh_d     = {tx_sh_q[WORD_W-2:0], 1'b0};
    assign rx_sh_d     = {rx_sh_q[WORD_W-2:0], i_SPI_MISO};

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            last_q    <= 1'b0;
            sclk_q    <= CPOL;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            ready_q   <= 1'b0;
            rx_dv_q   <= 1'b0;
            rx_word_q <= '0;
        end else begin
            rx_dv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cs_n_q  <= 1'b1;
                    sclk_q  <= CPOL;
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
                        cs_n_q  <= 1'b0;
                        tx_sh_q <= i_TX_Word;
                        last_q  <= i_TX_Last;
                        cnt_q   <= '0;
                        if (!CPHA) mosi_q <= i_TX_Word[WORD_W-1];
                        state_q <= CS_SETUP;
                    end
                end

                CS_SETUP: begin
                    if (half_tick) begin
                        cnt_q   <= '0;
                        edge_q  <= '0;
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                SHIFT: begin
                    if (edge_q == EDGE_DONE) begin
                        // All edges issued and the last sample taken: publish.
                        rx_dv_q   <= 1'b1;
                        rx_word_q <= rx_sh_q;
                        cnt_q     <= '0;
                        if (last_q) begin
                            cs_n_q  <= 1'b1;
                            state_q <= CS_IDLE;
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= HOLD;
                        end
                    end else if (half_tick) begin
                        cnt_q  <= '0;
                        edge_q <= edge_q + 1'b1;
                        sclk_q <= ~sclk_q;
                        if (sample_edge) begin
                            rx_sh_q <= rx_sh_d;
                        end else if (CPHA) begin
                            mosi_q  <= tx_sh_q[WORD_W-1];
                            tx_sh_q <= tx_sh_d;
                        end else if (edge_q != EDGE_LAST) begin
                            // CPHA=0 already presented the MSB; advance on
                            // trailing edges, holding MOSI after the last one.
                            mosi_q  <= tx_sh_q[WORD_W-2];
                            tx_sh_q <= tx_sh_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                HOLD: begin
                    sclk_q  <= CPOL;
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
                        tx_sh_q <= i_TX_Word;
                        last_q  <= i_TX_Last;
                        cnt_q   <= '0;
                        edge_q  <= '0;
                        if (!CPHA) mosi_q <= i_TX_Word[WORD_W-1];
                        state_q <= SHIFT;
                    end
                end

                CS_IDLE: begin
                    if (cnt_q == CSI_LAST) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_TX_Ready = ready_q;
    assign o_RX_DV    = rx_dv_q;
    assign o_RX_Word  = rx_word_q;
    assign o_SPI_Clk  = sclk_q;
    assign o_SPI_MOSI = mosi_q;
    assign o_SPI_CS_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_burst.sv
// -----------------------------------------------------------------------------
// tb_spi_master_burst
//   Three masters share one clock and reset:
//     k=0: WORD_W=8,  mode 0, half-bit 2, CS idle 2, MISO looped to MOSI
//     k=1: WORD_W=8,  mode 1, half-bit 2, CS idle 2, behavioural SPI slave
//     k=2: WORD_W=16, mode 3, half-bit 4, CS idle 3, MISO looped to MOSI
//   A pin monitor records SCLK edges, CS activity and received words; the
//   directed sequence compares those records with values derived from the
//   SPI rules (loopback returns what was sent, the slave exchanges words).
// -----------------------------------------------------------------------------
module tb_spi_master_burst;

    localparam int W_A    [3] = '{8, 8, 16};
    localparam int MODE_A [3] = '{0, 1, 3};
    localparam int CPHB_A [3] = '{2, 2, 4};
    localparam int CSI_A  [3] = '{2, 2, 3};
    localparam int CPOL_A [3] = '{0, 0, 1};
    localparam int LIMIT      = 5000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] tx_word_v [3] = '{16'h0, 16'h0, 16'h0};
    logic [2:0]  tx_dv_v   = '0;
    logic [2:0]  tx_last_v = '0;
    logic [2:0]  ready_w, rx_dv_w, sclk_w, mosi_w, cs_n_w, miso_w;
    logic [7:0]  rxw0, rxw1;
    logic [15:0] rxw2;
    logic        sl_miso = 1'b0;

    assign miso_w[0] = mosi_w[0];
    assign miso_w[1] = sl_miso;
    assign miso_w[2] = mosi_w[2];

    spi_master_burst #(.WORD_W(W_A[0]), .SPI_MODE(MODE_A[0]),
                       .CLKS_PER_HALF_BIT(CPHB_A[0]), .CS_INACTIVE_CLKS(CSI_A[0])) dut0 (
        .i_Clk(clk), .i_Rst(rst), .i_TX_Word(tx_word_v[0][7:0]), .i_TX_DV(tx_dv_v[0]),
        .i_TX_Last(tx_last_v[0]), .o_TX_Ready(ready_w[0]), .o_RX_DV(rx_dv_w[0]),
        .o_RX_Word(rxw0), .o_SPI_Clk(sclk_w[0]), .i_SPI_MISO(miso_w[0]),
        .o_SPI_MOSI(mosi_w[0]), .o_SPI_CS_n(cs_n_w[0]));

    spi_master_burst #(.WORD_W(W_A[1]), .SPI_MODE(MODE_A[1]),
                       .CLKS_PER_HALF_BIT(CPHB_A[1]), .CS_INACTIVE_CLKS(CSI_A[1])) dut1 (
        .i_Clk(clk), .i_Rst(rst), .i_TX_Word(tx_word_v[1][7:0]), .i_TX_DV(tx_dv_v[1]),
        .i_TX_Last(tx_last_v[1]), .o_TX_Ready(ready_w[1]), .o_RX_DV(rx_dv_w[1]),
        .o_RX_Word(rxw1), .o_SPI_Clk(sclk_w[1]), .i_SPI_MISO(miso_w[1]),
        .o_SPI_MOSI(mosi_w[1]), .o_SPI_CS_n(cs_n_w[1]));

    spi_master_burst #(.WORD_W(W_A[2]), .SPI_MODE(MODE_A[2]),
                       .CLKS_PER_HALF_BIT(CPHB_A[2]), .CS_INACTIVE_CLKS(CSI_A[2])) dut2 (
        .i_Clk(clk), .i_Rst(rst), .i_TX_Word(tx_word_v[2]), .i_TX_DV(tx_dv_v[2]),
        .i_TX_Last(tx_last_v[2]), .o_TX_Ready(ready_w[2]), .o_RX_DV(rx_dv_w[2]),
        .o_RX_Word(rxw2), .o_SPI_Clk(sclk_w[2]), .i_SPI_MISO(miso_w[2]),
        .o_SPI_MOSI(mosi_w[2]), .o_SPI_CS_n(cs_n_w[2]));

    function automatic logic [15:0] rx_word_of(input int k);
        case (k)
            0:       return {8'h00, rxw0};
            1:       return {8'h00, rxw1};
            default: return rxw2;
        endcase
    endfunction

    // ---------------- pin monitor ----------------
    int          cyc = 0;
    int          edges       [3] = '{0, 0, 0};
    int          last_edge   [3] = '{0, 0, 0};
    int          gap_err     [3] = '{0, 0, 0};
    int          cs_edge_err [3] = '{0, 0, 0};
    int          cs_pol_err  [3] = '{0, 0, 0};
    int          cs_falls    [3] = '{0, 0, 0};
    int          cs_gap      [3] = '{0, 0, 0};
    int          cs_hi_cnt   [3] = '{0, 0, 0};
    bit          counting    [3] = '{0, 0, 0};
    int          rx_n        [3] = '{0, 0, 0};
    logic [15:0] rx_log      [3][32];
    logic        prev_sclk   [3];
    logic        prev_cs     [3];

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                edges[k]    = 0;
                counting[k] = 1'b0;
            end else begin
                if (sclk_w[k] !== prev_sclk[k]) begin
                    if (cs_n_w[k] !== 1'b0) cs_edge_err[k]++;
                    if ((edges[k] % (2 * W_A[k])) != 0 && (cyc - last_edge[k]) != CPHB_A[k])
                        gap_err[k]++;
                    last_edge[k] = cyc;
                    edges[k]++;
                end
                if (cs_n_w[k] !== prev_cs[k]) begin
                    if (sclk_w[k] !== 1'(CPOL_A[k]) || prev_sclk[k] !== 1'(CPOL_A[k]))
                        cs_pol_err[k]++;
                    if (cs_n_w[k] === 1'b0) begin
                        cs_falls[k]++;
                    end else begin
                        counting[k]  = 1'b1;
                        cs_hi_cnt[k] = 0;
                    end
                end
                if (counting[k]) begin
                    if (cs_n_w[k] === 1'b1 && ready_w[k] === 1'b0) begin
                        cs_hi_cnt[k]++;
                    end else begin
                        cs_gap[k]   = cs_hi_cnt[k];
                        counting[k] = 1'b0;
                    end
                end
                if (rx_dv_w[k] === 1'b1) begin
                    if (rx_n[k] < 32) rx_log[k][rx_n[k]] = rx_word_of(k);
                    rx_n[k]++;
                end
            end
            prev_sclk[k] = sclk_w[k];
            prev_cs[k]   = cs_n_w[k];
        end
    end

    // ---------------- behavioural mode-1 slave on k=1 ----------------
    // CPOL=0, CPHA=1: present the next bit on each rising (leading) edge,
    // capture MOSI on each falling (trailing) edge.
    logic [7:0] sl_words [16];
    logic [7:0] sl_log   [32];
    logic [7:0] sl_sh  = '0;
    logic [7:0] sl_cap = '0;
    int         sl_bits = 0;
    int         sl_n    = 0;
    logic       sl_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            sl_bits = 0;
        end else if (sclk_w[1] !== sl_prev && cs_n_w[1] === 1'b0) begin
            if (sclk_w[1] === 1'b1) begin
                if (sl_bits == 0) sl_sh = sl_words[sl_n % 16];
                sl_miso = sl_sh[7];
                sl_sh   = {sl_sh[6:0], 1'b0};
            end else begin
                sl_cap = {sl_cap[6:0], mosi_w[1]};
                sl_bits++;
                if (sl_bits == 8) begin
                    sl_log[sl_n % 32] = sl_cap;
                    sl_n++;
                    sl_bits = 0;
                end
            end
        end
        sl_prev = sclk_w[1];
    end

    // ---------------- checking and stimulus helpers ----------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_word(input int k, input logic [15:0] w, input logic last, input logic keep);
        int t = 0;
        while (ready_w[k] !== 1'b1 && t < LIMIT) begin
            tick();
            t++;
        end
        check("ready_timeout", 32'(t < LIMIT), 32'd1);
        tx_word_v[k] = w;
        tx_last_v[k] = last;
        tx_dv_v[k]   = 1'b1;
        tick();
        if (!keep) tx_dv_v[k] = 1'b0;
    endtask

    task automatic wait_rx(input int k, input int target);
        int t = 0;
        while (rx_n[k] < target && t < LIMIT) begin
            tick();
            t++;
        end
        check("rx_timeout", 32'(t < LIMIT), 32'd1);
    endtask

    task automatic wait_idle(input int k);
        int t = 0;
        while (!(ready_w[k] === 1'b1 && cs_n_w[k] === 1'b1) && t < LIMIT) begin
            tick();
            t++;
        end
        check("idle_timeout", 32'(t < LIMIT), 32'd1);
    endtask

    logic [15:0] wbuf [8];

    task automatic send_burst(input int k, input int n);
        for (int i = 0; i < n; i++) send_word(k, wbuf[i], 1'(i == n - 1), 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base, fbase, ebase, sbase, k, n;
        logic [15:0] mask;

        // Reset state
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check("rst_cs_n",  32'(cs_n_w[i]),  32'd1);
            check("rst_sclk",  32'(sclk_w[i]),  32'(CPOL_A[i]));
            check("rst_mosi",  32'(mosi_w[i]),  32'd0);
            check("rst_ready", 32'(ready_w[i]), 32'd0);
            check("rst_rx_dv", 32'(rx_dv_w[i]), 32'd0);
            check("rst_rx_word", 32'(rx_word_of(i)), 32'd0);
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) check("ready_after_rst", 32'(ready_w[i]), 32'd1);

        // 1: single word, mode 0 loopback
        send_word(0, 16'h00C1, 1'b1, 1'b0);
        wait_rx(0, 1);
        wait_idle(0);
        check("t1_rx_word",  32'(rx_log[0][0]), 32'h00C1);
        check("t1_rx_count", 32'(rx_n[0]),      32'd1);
        check("t1_edges",    32'(edges[0]),     32'd16);
        check("t1_gap_err",  32'(gap_err[0]),   32'd0);
        check("t1_cs_falls", 32'(cs_falls[0]),  32'd1);
        check("t1_cs_gap",   32'(cs_gap[0]),    32'(CSI_A[0]));

        // 2: three-word burst under one CS assertion
        wbuf[0] = 16'h00C1; wbuf[1] = 16'h00A2; wbuf[2] = 16'h00B3;
        send_burst(0, 3);
        wait_rx(0, 4);
        wait_idle(0);
        check("t2_cs_falls", 32'(cs_falls[0]),  32'd2);
        check("t2_word0",    32'(rx_log[0][1]), 32'h00C1);
        check("t2_word1",    32'(rx_log[0][2]), 32'h00A2);
        check("t2_word2",    32'(rx_log[0][3]), 32'h00B3);
        check("t2_edges",    32'(edges[0]),     32'd64);
        check("t2_cs_gap",   32'(cs_gap[0]),    32'(CSI_A[0]));

        // 3: 16-bit word, mode 3, half-bit 4
        send_word(2, 16'hBEEF, 1'b1, 1'b0);
        wait_rx(2, 1);
        wait_idle(2);
        check("t3_rx_word", 32'(rx_log[2][0]), 32'hBEEF);
        check("t3_edges",   32'(edges[2]),     32'd32);
        check("t3_gap_err", 32'(gap_err[2]),   32'd0);
        check("t3_sclk_idle", 32'(sclk_w[2]),  32'd1);
        check("t3_cs_gap",  32'(cs_gap[2]),    32'(CSI_A[2]));

        // 4: mode 1 exchange with the slave model
        sl_words[sl_n % 16] = 8'h5A;
        sbase = sl_n;
        send_word(1, 16'h003C, 1'b1, 1'b0);
        wait_rx(1, 1);
        wait_idle(1);
        check("t4_slave_cap", 32'(sl_log[sbase % 32]), 32'h3C);
        check("t4_master_rx", 32'(rx_log[1][0]),       32'h5A);

        // 5: DV held high with a new word while busy
        base = rx_n[0];
        send_word(0, 16'h0012, 1'b1, 1'b1);
        tx_word_v[0] = 16'h00FF;
        send_word(0, 16'h00FF, 1'b1, 1'b0);
        wait_rx(0, base + 2);
        wait_idle(0);
        repeat (40) tick();
        check("t5_rx_count", 32'(rx_n[0] - base),    32'd2);
        check("t5_word0",    32'(rx_log[0][base]),   32'h0012);
        check("t5_word1",    32'(rx_log[0][base+1]), 32'h00FF);

        // 6: reset after the third SCLK edge
        base  = rx_n[0];
        ebase = edges[0];
        send_word(0, 16'h0077, 1'b1, 1'b0);
        n = 0;
        while (edges[0] - ebase < 3 && n < LIMIT) begin
            tick();
            n++;
        end
        check("t6_edge_timeout", 32'(n < LIMIT), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_cs_n_async", 32'(cs_n_w[0]), 32'd1);
        check("t6_sclk_async", 32'(sclk_w[0]), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("t6_ready_after", 32'(ready_w[0]), 32'd1);
        check("t6_no_rx_dv",    32'(rx_n[0]),    32'(base));
        send_word(0, 16'h0077, 1'b1, 1'b0);
        wait_rx(0, base + 1);
        wait_idle(0);
        check("t6_rx_word", 32'(rx_log[0][base]), 32'h0077);
        check("t6_edges",   32'(edges[0]),        32'd16);

        // 7: random bursts on every master
        for (int r = 0; r < 6; r++) begin
            k     = r % 3;
            n     = int'($urandom_range(1, 4));
            mask  = (W_A[k] == 16) ? 16'hFFFF : 16'h00FF;
            base  = rx_n[k];
            fbase = cs_falls[k];
            sbase = sl_n;
            for (int i = 0; i < n; i++) begin
                wbuf[i] = 16'($urandom) & mask;
                if (k == 1) sl_words[(sbase + i) % 16] = 8'($urandom);
            end
            send_burst(k, n);
            wait_rx(k, base + n);
            wait_idle(k);
            check("rnd_cs_falls", 32'(cs_falls[k] - fbase), 32'd1);
            for (int i = 0; i < n; i++) begin
                if (k == 1) begin
                    check("rnd_slave_cap", 32'(sl_log[(sbase + i) % 32]), 32'(wbuf[i][7:0]));
                    check("rnd_master_rx", 32'(rx_log[k][base + i]),      32'(sl_words[(sbase + i) % 16]));
                end else begin
                    check("rnd_loopback",  32'(rx_log[k][base + i]),      32'(wbuf[i]));
                end
            end
        end

        // SCLK/CS invariants over the whole run
        for (int i = 0; i < 3; i++) begin
            check("edge_while_cs_high", 32'(cs_edge_err[i]), 32'd0);
            check("cs_change_off_cpol", 32'(cs_pol_err[i]),  32'd0);
            check("edge_spacing",       32'(gap_err[i]),     32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
